// File: rtl/param_usr_if.sv
// Bus bundle for the param_usr shift register: control/data in, register state out.
interface param_usr_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] par_in;
    logic             si;
    logic             start;
    logic [WIDTH-1:0] q;
    logic             so_r;
    logic             so_l;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, par_in, si, start,
        input  q, so_r, so_l, busy, done
    );

    modport slave (
        input  en, mode, par_in, si, start,
        output q, so_r, so_l, busy, done
    );
endinterface

// File: rtl/param_usr.sv
// Universal shift register with mode-selected operations and an automatic
// LSB-first serialiser (IDLE/SHIFT FSM with a bit down-counter).
module param_usr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    param_usr_if.slave     bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               last_c;

    // Final bit of the serialisation is being shifted out this cycle.
    assign last_c = (cnt_q == CNT_W'(1));

    // State and datapath registers; reset clears everything without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state: start wins over mode in IDLE; en low stalls everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.en && bus.start) state_d = SHIFT;
            SHIFT:   if (bus.en && last_c)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: register update, counter and the completion pulse.
    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    if (bus.start) begin
                        q_d   = bus.par_in;
                        cnt_d = CNT_W'(WIDTH);
                    end else begin
                        case (bus.mode)
                            3'b000:  q_d = q_q;
                            3'b001:  q_d = {bus.si, q_q[WIDTH-1:1]};
                            3'b010:  q_d = {q_q[WIDTH-2:0], bus.si};
                            3'b011:  q_d = bus.par_in;
                            3'b100:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                            3'b101:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                            3'b110:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                            3'b111:  q_d = '0;
                            default: q_d = q_q;
                        endcase
                    end
                end
            end
            SHIFT: begin
                if (bus.en) begin
                    q_d    = {bus.si, q_q[WIDTH-1:1]};
                    cnt_d  = cnt_q - CNT_W'(1);
                    done_d = last_c;
                end
            end
            default: ;
        endcase
    end

    // Output mapping straight from the registers.
    assign bus.q    = q_q;
    assign bus.so_r = q_q[0];
    assign bus.so_l = q_q[WIDTH-1];
    assign bus.busy = (state_q == SHIFT);
    assign bus.done = done_q;
endmodule

// File: tb/tb_param_usr.sv
// Directed bench for param_usr (WIDTH=8): vector table for IDLE modes plus
// hand sequences for serialise, stall, abort and priority.
module tb_param_usr;
    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    param_usr_if #(.WIDTH(W)) bus ();

    param_usr #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic [2:0]   mode;
        logic [W-1:0] par_in;
        logic         si;
        logic         start;
        logic [W-1:0] exp_q;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic [2:0] mode, input logic [W-1:0] p,
                       input logic si, input logic st, input logic [W-1:0] eq);
        vec_t v;
        v.en = en; v.mode = mode; v.par_in = p; v.si = si; v.start = st; v.exp_q = eq;
        vecs.push_back(v);
    endtask

    // Serialise 0x3C LSB-first, optionally stalling two cycles after the 3rd bit.
    task automatic serialise(input bit stall);
        logic [W-1:0] pat;
        int busy_cycles;
        int done_seen;
        pat = 8'h3C;
        busy_cycles = 0;
        done_seen = 0;
        bus.en = 1'b1; bus.si = 1'b0; bus.mode = 3'b111; bus.par_in = pat; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ser_busy_k%0d", k), 32'(bus.busy), 32'd1);
            chk($sformatf("ser_so_r_k%0d", k), 32'(bus.so_r), 32'(pat[k]));
            if (bus.busy) busy_cycles++;
            if (bus.done) done_seen++;
            if (stall && k == 2) begin
                bus.en = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    step();
                    chk("stall_so_r", 32'(bus.so_r), 32'(pat[2]));
                    if (bus.busy) busy_cycles++;
                    if (bus.done) done_seen++;
                end
                bus.en = 1'b1;
            end
            step();
        end
        chk("ser_end_busy", 32'(bus.busy), 32'd0);
        chk("ser_end_done", 32'(bus.done), 32'd1);
        chk("ser_end_q", 32'(bus.q), 32'h00);
        if (bus.done) done_seen++;
        bus.mode = 3'b000;
        step();
        chk("ser_done_pulse_end", 32'(bus.done), 32'd0);
        if (bus.done) done_seen++;
        chk("ser_busy_cycles", 32'(busy_cycles), stall ? 32'd10 : 32'd8);
        chk("ser_done_count", 32'(done_seen), 32'd1);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        bus.en = 1'b0; bus.mode = 3'b000; bus.par_in = '0; bus.si = 1'b0; bus.start = 1'b0;
        #1;
        chk("rst_q_noclk", 32'(bus.q), 32'h00);
        chk("rst_busy_noclk", 32'(bus.busy), 32'd0);
        chk("rst_done_noclk", 32'(bus.done), 32'd0);
        step();
        rst = 1'b0;
        step();

        // IDLE mode table
        add(1, 3'b011, 8'hA5, 0, 0, 8'hA5);
        add(1, 3'b100, 8'h00, 0, 0, 8'hD2);
        add(1, 3'b011, 8'hA5, 0, 0, 8'hA5);
        add(1, 3'b101, 8'h00, 0, 0, 8'h4B);
        add(1, 3'b101, 8'h00, 0, 0, 8'h96);
        add(1, 3'b011, 8'h80, 0, 0, 8'h80);
        add(1, 3'b110, 8'h00, 1, 0, 8'hC0);
        add(1, 3'b011, 8'h80, 0, 0, 8'h80);
        add(1, 3'b010, 8'h00, 1, 0, 8'h01);
        add(1, 3'b001, 8'h00, 1, 0, 8'h80);
        add(0, 3'b111, 8'h00, 0, 0, 8'h80);
        add(0, 3'b011, 8'h55, 1, 1, 8'h80);
        add(1, 3'b000, 8'hFF, 1, 0, 8'h80);
        add(1, 3'b111, 8'hFF, 1, 0, 8'h00);
        add(1, 3'b011, 8'h5A, 0, 0, 8'h5A);
        add(1, 3'b001, 8'h00, 0, 0, 8'h2D);
        add(1, 3'b010, 8'h00, 0, 0, 8'h5A);
        add(1, 3'b110, 8'h00, 0, 0, 8'h2D);

        foreach (vecs[i]) begin
            bus.en = vecs[i].en; bus.mode = vecs[i].mode; bus.par_in = vecs[i].par_in;
            bus.si = vecs[i].si; bus.start = vecs[i].start;
            step();
            chk($sformatf("vec%0d_q", i), 32'(bus.q), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d_so_r", i), 32'(bus.so_r), 32'(vecs[i].exp_q[0]));
            chk($sformatf("vec%0d_so_l", i), 32'(bus.so_l), 32'(vecs[i].exp_q[W-1]));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd0);
        end
        bus.start = 1'b0;

        serialise(1'b0);
        serialise(1'b1);

        // Abort mid-serialise with an asynchronous reset
        bus.en = 1'b1; bus.si = 1'b0; bus.mode = 3'b000; bus.par_in = 8'h3C; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_q", 32'(bus.q), 32'h00);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_done", 32'(bus.done), 32'd0);
            chk("abort_idle", 32'(bus.busy), 32'd0);
        end

        // Start beats mode=111, and a start during busy is dropped
        bus.mode = 3'b111; bus.par_in = 8'hA5; bus.start = 1'b1;
        step();
        chk("prio_q", 32'(bus.q), 32'hA5);
        chk("prio_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        for (int k = 1; k < 8; k++) begin
            if (k == 3) begin
                bus.start = 1'b1;
                bus.par_in = 8'hFF;
            end else begin
                bus.start = 1'b0;
            end
            step();
            if (k == 4) chk("busy_start_ignored_q", 32'(bus.q), 32'h0A);
            chk("prio_busy_k", 32'(bus.busy), 32'd1);
        end
        bus.start = 1'b0;
        bus.mode = 3'b000;
        step();
        chk("prio_done", 32'(bus.done), 32'd1);
        chk("prio_end_q", 32'(bus.q), 32'h00);
        step();
        chk("prio_not_queued_busy", 32'(bus.busy), 32'd0);
        chk("prio_done_cleared", 32'(bus.done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/param_usr.md
PARAM_USR -- requirements
Module: param_usr

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port en  input  1  shift/load enable; low = hold (including mid-serialise).
REQ-005 SHALL have port mode  input  3  operation select in IDLE (see Function).
REQ-006 SHALL have port par_in  input  WIDTH  parallel load data.
REQ-007 SHALL have port si  input  1  serial input bit.
REQ-008 SHALL have port start  input  1  request automatic serialisation of par_in.
REQ-009 SHALL have port q  output  WIDTH  register contents.
REQ-010 SHALL have port so_r  output  1  right serial out, equals q[0].
REQ-011 SHALL have port so_l  output  1  left serial out, equals q[WIDTH-1].
REQ-012 SHALL have port busy  output  1  high while serialiser in SHIFT state.
REQ-013 SHALL have port done  output  1  one-cycle pulse on serialisation completion.

Function
REQ-014 SHALL implement FSM states IDLE and SHIFT; plus down-counter cnt of width clog2(WIDTH+1).
REQ-015 In IDLE with en=1 and start=0, SHALL update q per mode on each edge: 000 hold; 001 shift right, si into MSB; 010 shift left, si into LSB; 011 load par_in; 100 rotate right; 101 rotate left; 110 arithmetic shift right, MSB replicated, si ignored; 111 clear to 0.
REQ-016 In IDLE with en=0, SHALL hold q regardless of mode and start.
REQ-017 In IDLE with en=1 and start=1, SHALL load q<=par_in, cnt<=WIDTH, go to SHIFT; start has priority over mode.
REQ-018 In SHIFT, SHALL ignore mode and start; each edge with en=1 SHALL shift right (si into MSB) and decrement cnt.
REQ-019 In SHIFT with en=0, SHALL hold q, cnt, state (stall; no bit lost or repeated).
REQ-020 On the en=1 edge where cnt==1, SHALL perform final shift, return to IDLE, assert done for exactly the following cycle.
REQ-021 so_r SHALL present par_in bits LSB first: bit k visible during the k-th cycle (k from 0) of SHIFT, excluding stall cycles.
REQ-022 busy SHALL be combinationally state==SHIFT; high exactly WIDTH cycles plus stall cycles.
REQ-023 done SHALL be registered, never asserted together with busy.
REQ-024 start asserted while busy SHALL be dropped, not queued.
REQ-025 All width arithmetic SHALL be modulo WIDTH bits; no bit of q outside [WIDTH-1:0].

Reset
REQ-026 rst=1 SHALL immediately (no clock needed) force q=0, cnt=0, state=IDLE, busy=0, done=0.
REQ-027 rst asserted mid-SHIFT SHALL abort serialisation with no done pulse; first edge after rst release SHALL accept start normally.

Verification (WIDTH=8)
REQ-028 Reset: assert rst between edges -> q=0x00, busy=0, done=0 before next edge.
REQ-029 Rotate: load 0xA5 (mode 011); mode 100 one edge -> q=0xD2; reload 0xA5, mode 101 two edges -> q=0x4B then 0x96.
REQ-030 Shift/ASR: load 0x80; mode 110 one edge -> 0xC0; reload 0x80, mode 010 si=1 one edge -> 0x01; mode 001 si=1 from 0x01 -> 0x80; en=0 with mode 111 -> q unchanged.
REQ-031 Serialise: par_in=0x3C, si=0, start one cycle -> busy high 8 cycles, so_r = 0,0,1,1,1,1,0,0, then done high 1 cycle, q=0x00.
REQ-032 Stall: as REQ-031 with en=0 for 2 cycles after 3rd bit -> so_r sequence identical, 3rd bit held 3 cycles, busy high 10 cycles, single done.
REQ-033 Abort/priority: rst mid-serialise -> busy=0, no done, q=0; start during busy ignored; start with mode=111 in IDLE -> loads par_in, not clear.
